life_gen_sequencer: RTL and testbench

LIFE_GEN_SEQUENCER -- requirements
Module: life_gen_sequencer

---
 rtl/life_pkg.sv | 27 ++
 rtl/life_frame_divider.sv | 50 +++++
 rtl/life_gen_sequencer.sv | 153 +++++++++++++++
 tb/tb_life_gen_sequencer.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/life_pkg.sv
// life_pkg: shared sizing constants, FSM state encoding and the frame
// divider limit lookup for the life generation sequencer.
package life_pkg;

  localparam int BOARD_W_BITS   = 3;
  localparam int BOARD_H_BITS   = 3;
  localparam int CELL_BITS_DEF  = BOARD_W_BITS + BOARD_H_BITS;
  localparam int FRAME_CNT_BITS = 3;

  typedef enum logic {
    ST_COPY    = 1'b0,
    ST_COMPUTE = 1'b1
  } state_t;

  // Number of frames minus one between ticks: 2**speed - 1.
  function automatic logic [FRAME_CNT_BITS-1:0] frame_limit(input logic [1:0] speed);
    logic [FRAME_CNT_BITS-1:0] lim;
    case (speed)
      2'd0:    lim = 3'd0;
      2'd1:    lim = 3'd1;
      2'd2:    lim = 3'd3;
      default: lim = 3'd7;
    endcase
    return lim;
  endfunction

endpackage

// File: rtl/life_frame_divider.sv
// life_frame_divider: vsync rising-edge detect and frame-rate divider.
// tick_o fires on a vsync rise once 2**speed frames have elapsed; load_i
// sampled on a vsync rise restarts the frame count instead.
module life_frame_divider
  import life_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       vsync_i,
  input  logic [1:0] speed_i,
  input  logic       load_i,
  output logic       vrise_o,
  output logic       tick_o
);

  localparam logic [FRAME_CNT_BITS-1:0] FRAME_ONE = 1;

  logic                      vsync_q;
  logic [FRAME_CNT_BITS-1:0] frame_cnt_q;
  logic [FRAME_CNT_BITS-1:0] frame_cnt_d;
  logic                      at_limit;

  assign vrise_o  = vsync_i & ~vsync_q;
  assign at_limit = (frame_cnt_q >= frame_limit(speed_i));
  assign tick_o   = vrise_o & at_limit;

  // Frame counter advances once per vsync rise; cleared on tick or reload.
  always_comb begin
    frame_cnt_d = frame_cnt_q;
    if (vrise_o) begin
      if (load_i || at_limit) begin
        frame_cnt_d = '0;
      end else begin
        frame_cnt_d = frame_cnt_q + FRAME_ONE;
      end
    end
  end

  // Register vsync history and the frame count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vsync_q     <= 1'b0;
      frame_cnt_q <= '0;
    end else begin
      vsync_q     <= vsync_i;
      frame_cnt_q <= frame_cnt_d;
    end
  end

endmodule

// File: rtl/life_gen_sequencer.sv
// life_gen_sequencer: sweeps the life board one cell per tick, first copying
// curr into prev (COPY) then computing the next generation into curr
// (COMPUTE). Optional single-step support is built when LIFE_SINGLE_STEP_EN
// is defined; otherwise the step input is ignored.
//
//   state      | meaning
//   ST_COPY    | prev[cell] <= curr[cell] per tick, display curr
//   ST_COMPUTE | curr[cell] <= rule(prev) per tick, display prev
module life_gen_sequencer
  import life_pkg::*;
#(
  parameter int CELL_BITS = CELL_BITS_DEF
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 vsync,
  input  logic                 pause,
  input  logic                 pattern_load,
  input  logic [1:0]           speed,
  input  logic                 step,
  output logic [CELL_BITS-1:0] cell_idx,
  output logic [CELL_BITS-1:0] next_idx,
  output logic                 copy_we,
  output logic                 compute_we,
  output logic                 load_we,
  output logic                 disp_sel,
  output logic                 gen_done,
  output logic [7:0]           gen_count
);

  localparam logic [CELL_BITS-1:0] CELL_MAX = '1;
  localparam logic [CELL_BITS-1:0] CELL_ONE = 1;

  logic                 vrise;
  logic                 tick;
  logic                 tick_en;
  logic                 load_now;
  logic                 last_cell;
  logic                 gen_end;
  state_t               state_q;
  logic [CELL_BITS-1:0] cell_idx_q;
  logic [7:0]           gen_count_q;
  logic                 copy_we_q;
  logic                 compute_we_q;
  logic                 load_we_q;
  logic                 disp_sel_q;
  logic                 gen_done_q;

  life_frame_divider u_div (
    .clk     (clk),
    .rst_n   (rst_n),
    .vsync_i (vsync),
    .speed_i (speed),
    .load_i  (pattern_load),
    .vrise_o (vrise),
    .tick_o  (tick)
  );

  assign load_now  = vrise & pattern_load;
  assign last_cell = (cell_idx_q == CELL_MAX);
  // Last COMPUTE write of the sweep: the generation completes on this edge.
  assign gen_end   = compute_we_q & last_cell;

`ifdef LIFE_SINGLE_STEP_EN
  logic step_q;
  logic armed_q;

  // A step rise while paused arms ticks until the current generation ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      step_q  <= 1'b0;
      armed_q <= 1'b0;
    end else begin
      step_q <= step;
      if (load_now || gen_end) begin
        armed_q <= 1'b0;
      end else if (step && !step_q && pause) begin
        armed_q <= 1'b1;
      end
    end
  end

  assign tick_en = tick & (~pause | armed_q);
`else
  logic unused_step;
  assign unused_step = step;
  assign tick_en     = tick & ~pause;
`endif

  // Look-ahead index for the neighbour counter; only meaningful in COMPUTE.
  always_comb begin
    next_idx = '0;
    if (state_q == ST_COMPUTE && !last_cell) begin
      next_idx = cell_idx_q + CELL_ONE;
    end
  end

  // Sweep FSM: strobe one cycle after the tick, advance the cell as it ends.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_COPY;
      cell_idx_q   <= '0;
      gen_count_q  <= '0;
      copy_we_q    <= 1'b0;
      compute_we_q <= 1'b0;
      load_we_q    <= 1'b0;
      disp_sel_q   <= 1'b0;
      gen_done_q   <= 1'b0;
    end else begin
      copy_we_q    <= 1'b0;
      compute_we_q <= 1'b0;
      load_we_q    <= 1'b0;
      gen_done_q   <= 1'b0;
      if (load_now) begin
        load_we_q   <= 1'b1;
        state_q     <= ST_COPY;
        disp_sel_q  <= 1'b0;
        cell_idx_q  <= '0;
        gen_count_q <= '0;
      end else if (copy_we_q || compute_we_q) begin
        if (last_cell) begin
          cell_idx_q <= '0;
          if (state_q == ST_COPY) begin
            state_q    <= ST_COMPUTE;
            disp_sel_q <= 1'b1;
          end else begin
            state_q     <= ST_COPY;
            disp_sel_q  <= 1'b0;
            gen_done_q  <= 1'b1;
            gen_count_q <= gen_count_q + 8'd1;
          end
        end else begin
          cell_idx_q <= cell_idx_q + CELL_ONE;
        end
      end else if (tick_en) begin
        if (state_q == ST_COPY) begin
          copy_we_q <= 1'b1;
        end else begin
          compute_we_q <= 1'b1;
        end
      end
    end
  end

  assign cell_idx   = cell_idx_q;
  assign copy_we    = copy_we_q;
  assign compute_we = compute_we_q;
  assign load_we    = load_we_q;
  assign disp_sel   = disp_sel_q;
  assign gen_done   = gen_done_q;
  assign gen_count  = gen_count_q;

endmodule

// File: tb/tb_life_gen_sequencer.sv
// Scoreboard bench for life_gen_sequencer. Each vsync frame pushes the
// strobes it should cause; a negedge monitor pops and compares them.
module tb_life_gen_sequencer;

  localparam int CB = 6;
  localparam logic [3:0] K_COPY = 4'b1000;
  localparam logic [3:0] K_COMP = 4'b0100;
  localparam logic [3:0] K_LOAD = 4'b0010;
  localparam logic [3:0] K_GD   = 4'b0001;

  logic          clk = 1'b0;
  logic          rst_n, vsync, pause, pattern_load, step;
  logic [1:0]    speed;
  logic [CB-1:0] cell_idx, next_idx;
  logic          copy_we, compute_we, load_we, disp_sel, gen_done;
  logic [7:0]    gen_count;

  typedef struct packed {
    logic [3:0]    kind;
    logic [CB-1:0] idx;
    logic [CB-1:0] nidx;
    logic          disp;
    logic [7:0]    gen;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int checks = 0, errors = 0;
  int sweep_cnt = 0, load_cnt = 0, gd_cnt = 0;
  int m_state, m_idx, m_gen, m_frame;
  bit m_armed;
  int base_sw, base_ld, base_gd, guard;

  always #5 clk = ~clk;

  life_gen_sequencer dut (
    .clk(clk), .rst_n(rst_n), .vsync(vsync), .pause(pause),
    .pattern_load(pattern_load), .speed(speed), .step(step),
    .cell_idx(cell_idx), .next_idx(next_idx), .copy_we(copy_we),
    .compute_we(compute_we), .load_we(load_we), .disp_sel(disp_sel),
    .gen_done(gen_done), .gen_count(gen_count)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push(input logic [3:0] kind, input int idx, input int nidx,
                      input int disp, input int gen);
    exp_t e;
    e.kind = kind;
    e.idx  = CB'(idx);
    e.nidx = CB'(nidx);
    e.disp = disp[0];
    e.gen  = gen[7:0];
    exp_q.push_back(e);
  endtask

  // Predict the effect of one frame, then drive it (vsync high 2, low 2).
  task automatic frame(input bit load);
    bit tk;
    if (load) begin
      push(K_LOAD, 0, 0, 0, 0);
      m_state = 0; m_idx = 0; m_gen = 0; m_frame = 0; m_armed = 0;
    end else begin
      tk = (m_frame >= (1 << speed) - 1);
      if (tk) m_frame = 0; else m_frame++;
      if (tk && (!pause || m_armed)) begin
        if (m_state == 0) push(K_COPY, m_idx, 0, 0, m_gen);
        else push(K_COMP, m_idx, (m_idx < 63) ? m_idx + 1 : 0, 1, m_gen);
        if (m_idx == 63) begin
          m_idx = 0;
          if (m_state == 1) begin
            m_gen = (m_gen + 1) % 256;
            m_armed = 0;
            m_state = 0;
            push(K_GD, 0, 0, 0, m_gen);
          end else begin
            m_state = 1;
          end
        end else begin
          m_idx++;
        end
      end
    end
    pattern_load = load;
    vsync = 1'b1;
    @(posedge clk); #1;
    pattern_load = 1'b0;
    @(posedge clk); #1;
    vsync = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
  endtask

  task automatic step_pulse();
    step = 1'b1;
    @(posedge clk); #1;
    step = 1'b0;
    @(posedge clk); #1;
`ifdef LIFE_SINGLE_STEP_EN
    if (pause && !m_armed) m_armed = 1;
`endif
  endtask

  // Monitor: every strobe cycle must match the head of the scoreboard.
  always @(negedge clk) begin
    if (copy_we | compute_we | load_we | gen_done) begin
      if (copy_we | compute_we) sweep_cnt++;
      if (load_we) load_cnt++;
      if (gen_done) gd_cnt++;
      chk("strobe_exclusive", int'($countones({copy_we, compute_we, load_we}) > 1), 0);
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got kind=%b idx=%0d expected none",
                 {copy_we, compute_we, load_we, gen_done}, cell_idx);
      end else begin
        mon_e = exp_q.pop_front();
        chk("sb_kind", int'({copy_we, compute_we, load_we, gen_done}), int'(mon_e.kind));
        chk("sb_cell_idx", int'(cell_idx), int'(mon_e.idx));
        chk("sb_next_idx", int'(next_idx), int'(mon_e.nidx));
        chk("sb_disp_sel", int'(disp_sel), int'(mon_e.disp));
        chk("sb_gen_count", int'(gen_count), int'(mon_e.gen));
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; vsync = 1'b0; pause = 1'b0; pattern_load = 1'b0;
    step = 1'b0; speed = 2'd0;
    m_state = 0; m_idx = 0; m_gen = 0; m_frame = 0; m_armed = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cell_idx", int'(cell_idx), 0);
    chk("rst_next_idx", int'(next_idx), 0);
    chk("rst_disp_sel", int'(disp_sel), 0);
    chk("rst_gen_count", int'(gen_count), 0);
    chk("rst_strobes", int'({copy_we, compute_we, load_we, gen_done}), 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // 64 copies, then COMPUTE at cell 0
    repeat (64) frame(0);
    chk("copy_sweep_count", sweep_cnt, 64);
    chk("after_copy_cell", int'(cell_idx), 0);
    chk("after_copy_disp", int'(disp_sel), 1);
    chk("compute_next_idx0", int'(next_idx), 1);

    // Compute sweep, boundary at cell 63
    repeat (63) frame(0);
    chk("last_cell_idx", int'(cell_idx), 63);
    chk("last_cell_next_idx", int'(next_idx), 0);
    frame(0);
    chk("gen_done_once", gd_cnt, 1);
    chk("gen_count_one", int'(gen_count), 1);
    chk("gen_end_disp", int'(disp_sel), 0);
    chk("gen_end_next_idx", int'(next_idx), 0);

    // speed=2: one strobe per 4 frames, then switch to speed 0 mid-count
    speed = 2'd2;
    base_sw = sweep_cnt;
    repeat (8) frame(0);
    chk("speed2_strobes", sweep_cnt - base_sw, 2);
    base_sw = sweep_cnt;
    repeat (2) frame(0);
    chk("speed2_partial", sweep_cnt - base_sw, 0);
    speed = 2'd0;
    frame(0);
    chk("speed_change_strobe", sweep_cnt - base_sw, 1);

    // Reload mid-COMPUTE at cell 37
    guard = 0;
    while (!(m_state == 1 && m_idx == 37) && guard < 300) begin
      frame(0);
      guard++;
    end
    chk("mid_compute_cell", int'(cell_idx), 37);
    chk("mid_compute_disp", int'(disp_sel), 1);
    chk("mid_compute_next", int'(next_idx), 38);
    base_ld = load_cnt;
    base_sw = sweep_cnt;
    frame(1);
    chk("load_pulse", load_cnt - base_ld, 1);
    chk("load_no_sweep", sweep_cnt - base_sw, 0);
    chk("load_cell_idx", int'(cell_idx), 0);
    chk("load_disp_sel", int'(disp_sel), 0);
    chk("load_gen_count", int'(gen_count), 0);

    // Pause, then single-step request
    repeat (5) frame(0);
    pause = 1'b1;
    base_sw = sweep_cnt;
    repeat (200) frame(0);
    chk("paused_strobes", sweep_cnt - base_sw, 0);
    base_sw = sweep_cnt;
    base_gd = gd_cnt;
    step_pulse();
    repeat (140) frame(0);
`ifdef LIFE_SINGLE_STEP_EN
    chk("step_strobes", sweep_cnt - base_sw, 123);
    chk("step_gen_done", gd_cnt - base_gd, 1);
`else
    chk("step_ignored_strobes", sweep_cnt - base_sw, 0);
    chk("step_ignored_gen_done", gd_cnt - base_gd, 0);
`endif
    pause = 1'b0;

    // Reset mid-sweep at cell 20
    guard = 0;
    while (!(m_state == 0 && m_idx == 20) && guard < 300) begin
      frame(0);
      guard++;
    end
    chk("pre_reset_cell", int'(cell_idx), 20);
    base_gd = gd_cnt;
    rst_n = 1'b0;
    @(posedge clk); #1;
    chk("mid_rst_cell_idx", int'(cell_idx), 0);
    chk("mid_rst_disp_sel", int'(disp_sel), 0);
    chk("mid_rst_gen_count", int'(gen_count), 0);
    chk("mid_rst_strobes", int'({copy_we, compute_we, load_we, gen_done}), 0);
    rst_n = 1'b1;
    m_state = 0; m_idx = 0; m_gen = 0; m_frame = 0; m_armed = 0;
    repeat (10) @(posedge clk);
    #1;
    chk("rst_no_gen_done", gd_cnt - base_gd, 0);
    repeat (3) frame(0);
    chk("post_rst_cell", int'(cell_idx), 3);
    chk("scoreboard_drained", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
